// File: rtl/uart_sync_fifo_if.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo_if
// Bus bundle for the UART single-clock FIFO.
//   master : the side that pushes/pops words (host or UART engine)
//            drives wr_en, din, rd_en, flush, err_clr
//            observes dout, count, full/empty, almost flags, error flags
//   slave  : the FIFO itself (the mirror image of master)
// DEPTH must match the FIFO instance so that count has the right width.
// ---------------------------------------------------------------------------
interface uart_sync_fifo_if #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 16
);
  localparam int CW = $clog2(DEPTH + 1);

  logic                  wr_en;
  logic [DATA_WIDTH-1:0] din;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] dout;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [CW-1:0]         count;
  logic                  flush;
  logic                  err_clr;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output wr_en, din, rd_en, flush, err_clr,
    input  dout, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );

  modport slave (
    input  wr_en, din, rd_en, flush, err_clr,
    output dout, full, empty, almost_full, almost_empty, count,
           overflow, underflow
  );
endinterface

// File: rtl/uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// uart_sync_fifo
// Parametrised single-clock first-word-fall-through FIFO for the UART TX/RX
// data paths. Any DEPTH >= 2 is supported, including non-powers of two.
// Ports:
//   clk    : single clock, rising edge
//   reset  : asynchronous, active-high
//   bus    : uart_sync_fifo_if.slave
//            wr_en/din     push a word (dropped when full and no pop)
//            rd_en         pop the head word
//            dout          head word, valid whenever empty = 0
//            count         exact occupancy 0..DEPTH
//            full/empty/almost_full/almost_empty  decoded from count only
//            flush         synchronous clear of contents
//            err_clr       clears the sticky overflow/underflow flags
// ---------------------------------------------------------------------------
module uart_sync_fifo #(
  parameter int DATA_WIDTH    = 8,
  parameter int DEPTH         = 16,
  parameter int AFULL_THRESH  = 12,
  parameter int AEMPTY_THRESH = 4
) (
  input  logic            clk,
  input  logic            reset,
  uart_sync_fifo_if.slave bus
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count_r;
  logic                  overflow_r;
  logic                  underflow_r;

  logic empty_w;
  logic full_w;
  logic rd_acc;
  logic wr_acc;
  logic ovf_set;
  logic udf_set;

  // Pointers wrap by explicit compare so DEPTH need not be a power of two.
  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Flags decode the count register only, so no request input reaches them
  // combinationally.
  assign empty_w = (count_r == '0);
  assign full_w  = (count_r == CW'(DEPTH));

  // A pop frees a slot in the same edge, so a full FIFO still takes a write
  // when it is read at the same time.
  assign rd_acc  = bus.rd_en & ~empty_w;
  assign wr_acc  = bus.wr_en & (~full_w | rd_acc);

  // Flush swallows the requests of its cycle, including their error effects.
  assign ovf_set = bus.wr_en & ~wr_acc & ~bus.flush;
  assign udf_set = bus.rd_en & empty_w & ~bus.flush;

  // Storage is deliberately left out of reset; stale words are never visible
  // because dout is only meaningful while count is non-zero.
  always_ff @(posedge clk) begin
    if (wr_acc && !bus.flush) begin
      mem[wr_ptr] <= bus.din;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count_r     <= '0;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (bus.flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        count_r <= '0;
      end else begin
        if (wr_acc) begin
          wr_ptr <= next_ptr(wr_ptr);
        end
        if (rd_acc) begin
          rd_ptr <= next_ptr(rd_ptr);
        end
        case ({wr_acc, rd_acc})
          2'b10:   count_r <= count_r + CW'(1);
          2'b01:   count_r <= count_r - CW'(1);
          default: count_r <= count_r;
        endcase
      end
      // A new error event wins over a clear arriving in the same cycle.
      overflow_r  <= ovf_set | (overflow_r  & ~bus.err_clr);
      underflow_r <= udf_set | (underflow_r & ~bus.err_clr);
    end
  end

  assign bus.dout         = mem[rd_ptr];
  assign bus.count        = count_r;
  assign bus.empty        = empty_w;
  assign bus.full         = full_w;
  assign bus.almost_full  = (count_r >= CW'(AFULL_THRESH));
  assign bus.almost_empty = (count_r <= CW'(AEMPTY_THRESH));
  assign bus.overflow     = overflow_r;
  assign bus.underflow    = underflow_r;

endmodule

// File: tb/tb_uart_sync_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_sync_fifo
// Drives a DEPTH=16 and a DEPTH=5 FIFO with identical stimulus. A list-based
// reference model per FIFO predicts occupancy, flags and popped words; popped
// words go into scoreboard queues that a negedge monitor consumes whenever a
// DUT actually presents a read.
// ---------------------------------------------------------------------------
module tb_uart_sync_fifo;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       flush = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] din = 8'h00;

  always #5 clk = ~clk;

  uart_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(16)) bus16 ();
  uart_sync_fifo_if #(.DATA_WIDTH(8), .DEPTH(5))  bus5 ();

  assign bus16.wr_en   = wr_en;
  assign bus16.din     = din;
  assign bus16.rd_en   = rd_en;
  assign bus16.flush   = flush;
  assign bus16.err_clr = err_clr;
  assign bus5.wr_en    = wr_en;
  assign bus5.din      = din;
  assign bus5.rd_en    = rd_en;
  assign bus5.flush    = flush;
  assign bus5.err_clr  = err_clr;

  uart_sync_fifo #(.DATA_WIDTH(8), .DEPTH(16), .AFULL_THRESH(12), .AEMPTY_THRESH(4)) dut16 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus16.slave)
  );

  uart_sync_fifo #(.DATA_WIDTH(8), .DEPTH(5), .AFULL_THRESH(4), .AEMPTY_THRESH(1)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5.slave)
  );

  // Reference model: mdata[i][0] is the oldest stored word.
  logic [7:0] mdata [2][16];
  int         mcnt [2];
  bit         movf [2];
  bit         mudf [2];
  logic [7:0] exp16 [$];
  logic [7:0] exp5 [$];

  int vectors = 0;
  int miscompares = 0;

  function automatic int depthOf(int i);
    return (i == 0) ? 16 : 5;
  endfunction

  function automatic int afThr(int i);
    return (i == 0) ? 12 : 4;
  endfunction

  function automatic int aeThr(int i);
    return (i == 0) ? 4 : 1;
  endfunction

  task automatic checkValue(string name, int act, int req);
    vectors++;
    if (act != req) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  task automatic resetModel();
    for (int i = 0; i < 2; i++) begin
      mcnt[i] = 0;
      movf[i] = 1'b0;
      mudf[i] = 1'b0;
    end
    exp16.delete();
    exp5.delete();
  endtask

  // Advances both models by one clock using the currently driven inputs.
  task automatic modelStep();
    for (int i = 0; i < 2; i++) begin
      bit         rok;
      bit         wok;
      logic [7:0] head;
      if (flush) begin
        mcnt[i] = 0;
        movf[i] = movf[i] & ~err_clr;
        mudf[i] = mudf[i] & ~err_clr;
      end else begin
        rok = rd_en && (mcnt[i] > 0);
        wok = wr_en && ((mcnt[i] < depthOf(i)) || rok);
        movf[i] = (wr_en && !wok) || (movf[i] && !err_clr);
        mudf[i] = (rd_en && (mcnt[i] == 0)) || (mudf[i] && !err_clr);
        if (rok) begin
          head = mdata[i][0];
          if (i == 0) exp16.push_back(head);
          else        exp5.push_back(head);
          for (int k = 0; k < 15; k++) mdata[i][k] = mdata[i][k+1];
          mcnt[i]--;
        end
        if (wok) begin
          mdata[i][mcnt[i]] = din;
          mcnt[i]++;
        end
      end
    end
  endtask

  task automatic checkOutput(string tag);
    for (int i = 0; i < 2; i++) begin
      int    c;
      bit    f, e, af, ae, ov, un;
      int    d;
      string p;
      if (i == 0) begin
        c = int'(bus16.count); f = bus16.full; e = bus16.empty;
        af = bus16.almost_full; ae = bus16.almost_empty;
        ov = bus16.overflow; un = bus16.underflow; d = int'(bus16.dout);
      end else begin
        c = int'(bus5.count); f = bus5.full; e = bus5.empty;
        af = bus5.almost_full; ae = bus5.almost_empty;
        ov = bus5.overflow; un = bus5.underflow; d = int'(bus5.dout);
      end
      p = $sformatf("%s d%0d", tag, depthOf(i));
      checkValue({p, " count"}, c, mcnt[i]);
      checkValue({p, " full"}, int'(f), int'(mcnt[i] == depthOf(i)));
      checkValue({p, " empty"}, int'(e), int'(mcnt[i] == 0));
      checkValue({p, " almost_full"}, int'(af), int'(mcnt[i] >= afThr(i)));
      checkValue({p, " almost_empty"}, int'(ae), int'(mcnt[i] <= aeThr(i)));
      checkValue({p, " overflow"}, int'(ov), int'(movf[i]));
      checkValue({p, " underflow"}, int'(un), int'(mudf[i]));
      if (mcnt[i] > 0) checkValue({p, " dout"}, d, int'(mdata[i][0]));
    end
  endtask

  // Called at posedge+1: drive one cycle, predict it, check after the edge.
  task automatic applyStimulus(bit w, logic [7:0] d, bit r, bit fl, bit ec, string tag);
    wr_en   = w;
    din     = d;
    rd_en   = r;
    flush   = fl;
    err_clr = ec;
    modelStep();
    @(posedge clk);
    #1;
    checkOutput(tag);
  endtask

  // Scoreboard monitor: mid-cycle, a read that the DUT will accept at the
  // next edge must show the oldest expected word on dout.
  logic [7:0] want16, want5;
  always @(negedge clk) begin
    if (!reset && !flush && rd_en) begin
      if (!bus16.empty) begin
        if (exp16.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL d16 read: got %0d, expected no read (t=%0t)", bus16.dout, $time);
        end else begin
          want16 = exp16.pop_front();
          checkValue("d16 read data", int'(bus16.dout), int'(want16));
        end
      end
      if (!bus5.empty) begin
        if (exp5.size() == 0) begin
          vectors++;
          miscompares++;
          $display("[TB] FAIL d5 read: got %0d, expected no read (t=%0t)", bus5.dout, $time);
        end else begin
          want5 = exp5.pop_front();
          checkValue("d5 read data", int'(bus5.dout), int'(want5));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int wprob;
    int rprob;
    resetModel();
    @(posedge clk);
    @(posedge clk);
    #1;
    checkOutput("reset");
    reset = 1'b0;

    // Fill with 0x11..0x1F, then one more to reach full, then drain.
    for (int k = 0; k < 15; k++) applyStimulus(1, 8'(8'h11 + k), 0, 0, 0, "fill15");
    applyStimulus(1, 8'h20, 0, 0, 0, "fill16");
    for (int k = 0; k < 17; k++) applyStimulus(0, 8'h00, 1, 0, 0, "drain");
    applyStimulus(0, 8'h00, 0, 0, 1, "errclr1");

    // Full FIFO with simultaneous write and read keeps count and takes the word.
    for (int k = 0; k < 16; k++) applyStimulus(1, 8'(8'h40 + k), 0, 0, 0, "refill");
    applyStimulus(1, 8'hA5, 1, 0, 0, "full wr+rd");
    applyStimulus(0, 8'h00, 0, 0, 1, "errclr2");

    // Full FIFO write-only drops the word and sets overflow; err_clr clears it.
    applyStimulus(1, 8'h77, 0, 0, 0, "full wr");
    applyStimulus(0, 8'h00, 0, 0, 1, "errclr3");
    applyStimulus(1, 8'h78, 0, 0, 1, "set beats clr");
    applyStimulus(0, 8'h00, 0, 0, 1, "errclr4");
    for (int k = 0; k < 16; k++) applyStimulus(0, 8'h00, 1, 0, 0, "drain2");

    // Empty read sets underflow; a write then falls straight through to dout.
    applyStimulus(0, 8'h00, 1, 0, 0, "empty rd");
    applyStimulus(1, 8'h3C, 0, 0, 0, "fallthrough");
    applyStimulus(0, 8'h00, 1, 0, 1, "pop 3C");

    // Write/read pairs 0..11 walk the DEPTH=5 pointers around several times.
    for (int k = 0; k < 12; k++) begin
      applyStimulus(1, 8'(k), 0, 0, 0, "pair wr");
      applyStimulus(0, 8'h00, 1, 0, 0, "pair rd");
    end
    for (int k = 0; k < 12; k++) applyStimulus(1, 8'(8'h80 + k), (k > 2), 0, 0, "stream");
    for (int k = 0; k < 4; k++) applyStimulus(0, 8'h00, 1, 0, 0, "stream drain");

    // Flush with a concurrent write empties the FIFO and raises no error.
    for (int k = 0; k < 7; k++) applyStimulus(1, 8'(8'hC0 + k), 0, 0, 0, "pre flush");
    applyStimulus(1, 8'hEE, 1, 1, 0, "flush");
    applyStimulus(1, 8'h5A, 0, 0, 0, "post flush");

    // Asynchronous reset mid-burst, checked before any further clock edge.
    applyStimulus(1, 8'h5B, 0, 0, 0, "burst");
    wr_en = 1'b1;
    din   = 8'h5C;
    #2;
    reset = 1'b1;
    resetModel();
    #1;
    checkOutput("async reset");
    wr_en = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("reset release");

    // Randomised traffic with phases biased toward filling and draining.
    for (int n = 0; n < 600; n++) begin
      case ((n / 75) % 4)
        0:       begin wprob = 80; rprob = 30; end
        1:       begin wprob = 25; rprob = 80; end
        2:       begin wprob = 60; rprob = 60; end
        default: begin wprob = 95; rprob = 90; end
      endcase
      applyStimulus($urandom_range(0, 99) < wprob, 8'($urandom),
                    $urandom_range(0, 99) < rprob,
                    $urandom_range(0, 99) < 2,
                    $urandom_range(0, 99) < 6, "random");
    end
    applyStimulus(0, 8'h00, 0, 0, 0, "idle");

    checkValue("scoreboard drained", exp16.size() + exp5.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
